imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Program-image writer for the instruction memory the fetch stage reads. Takes a
//  byte stream (valid/ready), assembles little-endian 32-bit words, writes them
//  to IMEM at sequential word addresses, and holds the core in reset (core_rst_n=0)
//  until the full image is loaded. Sits between the host link (UART RX) and IMEM.
// PARAMETERS
//  DEPTH_WORDS  1024   IMEM capacity in 32-bit words; max legal image length
//  ADDR_W       32     width of mem_addr (byte address)
//  BASE_ADDR    0      byte address of first loaded word
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       begin a load (honoured in IDLE, DONE, ERR only)
//  rx_data     in   8       stream byte
//  rx_valid    in   1       rx_data valid
//  rx_ready    out  1       loader can accept a byte
//  mem_we      out  1       IMEM write strobe, 1-cycle pulse per word
//  mem_addr    out  ADDR_W  IMEM byte address of write
//  mem_wdata   out  32      IMEM write data
//  core_rst_n  out  1       active-low reset to core; 1 only in DONE
//  done        out  1       image loaded
//  err         out  1       header word count > DEPTH_WORDS
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE; rx_ready, mem_we, done, err,
//    core_rst_n = 0; mem_addr, mem_wdata = 0; byte_idx, word_idx, count = 0.
//  - Byte accepted iff rx_valid && rx_ready at posedge. Byte k (k=0..3) of a word
//    goes to bits [8k+7:8k]. byte_idx wraps 3->0 on 4th accepted byte.
//  - Frame: 4-byte header = word count N (LE, 32 bit), then N words of 4 bytes.
//  - States (all outputs registered):
//    IDLE : rx_ready=0. start -> HDR.
//    HDR  : rx_ready=1. On 4th byte: N==0 -> DONE; N>DEPTH_WORDS -> ERR; else DATA.
//    DATA : rx_ready=1. On 4th byte -> WRITE.
//    WRITE: one cycle, rx_ready=0, mem_we=1, mem_addr=BASE_ADDR+4*word_idx,
//           mem_wdata=assembled word; word_idx+1; if word_idx+1==N -> DONE else DATA.
//    DONE : done=1, core_rst_n=1. start -> HDR (done=0, core_rst_n=0, counters cleared).
//    ERR  : err=1, core_rst_n=0, no writes. start -> HDR (err=0, counters cleared).
//  - mem_we high only in WRITE; mem_addr/mem_wdata hold last value otherwise.
//  - Latency: mem_we asserted the cycle after the word's 4th byte is accepted.
//  - start in HDR/DATA/WRITE ignored. rx_valid with rx_ready=0: byte not consumed.
//  - Address arithmetic modulo 2^ADDR_W; N compared as unsigned 32-bit.
//  - rst mid-load: immediate return to IDLE, core_rst_n=0; words already written
//    stay in IMEM; partial word discarded.
// TESTING
//  1 Reset: rst=1 two cycles -> all outputs 0, core_rst_n=0, rx_ready=0.
//  2 start; bytes 02 00 00 00, 93 00 50 00, 13 01 A0 00 back-to-back -> mem_we
//    pulses: addr 0x0 data 0x00500093, addr 0x4 data 0x00A00113; next cycle
//    done=1, core_rst_n=1; exactly 2 writes.
//  3 Same image with rx_valid toggling randomly (gaps, valid held while ready=0
//    in WRITE) -> identical writes, no byte double-counted or dropped.
//  4 Header 00 00 00 00 -> DONE cycle after 4th byte, zero mem_we pulses.
//  5 Header = DEPTH_WORDS+1 (0x401) -> err=1, no writes, core_rst_n=0; then start
//    + valid 1-word image -> err=0, one write, done=1.
//  6 rst=1 after first of 3 words written -> IDLE, no further mem_we, core_rst_n=0;
//    restart with full image -> all 3 words written, done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Program-image loader: assembles a little-endian byte stream into 32-bit words,
// writes them to IMEM at sequential addresses and releases the core once loaded.
//
// state | meaning
// IDLE  | waiting for start, stream not accepted
// HDR   | collecting the 4-byte word count N
// DATA  | collecting the 4 bytes of the next image word
// WRITE | one-cycle IMEM write of the assembled word
// DONE  | image complete, core released from reset
// ERR   | header count exceeded IMEM capacity, nothing written
module imem_loader #(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_next;
    logic [1:0]        byte_idx, byte_idx_next;
    logic [23:0]       word_buf, word_buf_next;
    logic [31:0]       word_idx, word_idx_next;
    logic [31:0]       count, count_next;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       wdata_next;
    logic [31:0]       full_word;
    logic              accept;
    logic              clear;

    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        word_buf_next = word_buf;
        word_idx_next = word_idx;
        count_next    = count;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        clear         = 1'b0;
        accept        = rx_valid && rx_ready;
        // Only meaningful when the 4th byte is on rx_data.
        full_word     = {rx_data, word_buf};

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_HDR;
                    clear      = 1'b1;
                end
            end
            S_HDR: begin
                if (accept && byte_idx == 2'd3) begin
                    count_next = full_word;
                    if (full_word == 32'd0)
                        state_next = S_DONE;
                    else if (full_word > 32'(DEPTH_WORDS))
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_idx == 2'd3) begin
                    state_next = S_WRITE;
                    addr_next  = BASE_ADDR + (ADDR_W'(word_idx) << 2);
                    wdata_next = full_word;
                end
            end
            S_WRITE: begin
                word_idx_next = word_idx + 32'd1;
                if (word_idx + 32'd1 == count)
                    state_next = S_DONE;
                else
                    state_next = S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_HDR;
                    clear      = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (accept) begin
            byte_idx_next = byte_idx + 2'd1;
            case (byte_idx)
                2'd0: word_buf_next[7:0]   = rx_data;
                2'd1: word_buf_next[15:8]  = rx_data;
                2'd2: word_buf_next[23:16] = rx_data;
                2'd3: ;
                default: ;
            endcase
        end

        if (clear) begin
            byte_idx_next = 2'd0;
            word_buf_next = 24'd0;
            word_idx_next = 32'd0;
            count_next    = 32'd0;
        end
    end

    // Outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            word_idx   <= 32'd0;
            count      <= 32'd0;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            byte_idx   <= byte_idx_next;
            word_buf   <= word_buf_next;
            word_idx   <= word_idx_next;
            count      <= count_next;
            rx_ready   <= (state_next == S_HDR) || (state_next == S_DATA);
            mem_we     <= (state_next == S_WRITE);
            mem_addr   <= addr_next;
            mem_wdata  <= wdata_next;
            core_rst_n <= (state_next == S_DONE);
            done       <= (state_next == S_DONE);
            err        <= (state_next == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built images and checks the IMEM
// write sequence and status outputs against expected values.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] imem [0:15];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM model: log every write strobe.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (mem_addr[31:2] < 16) imem[mem_addr[5:2]] = mem_wdata;
        end
    end

    // Called at a negedge; returns at the negedge after the byte is consumed.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent;
        sent = 1'b0;
        for (int i = 0; i < 100 && !sent; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'hEE;
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                if (rx_ready === 1'b1) sent = 1'b1;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!sent) begin
            miscompares++;
            $display("FAIL send_byte_timeout byte=%02h never accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[7:0], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[31:24], gaps);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rx_ready, mem_we, done, err, core_rst_n} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got rdy/we/done/err/crst=%b expected 00000",
                     {rx_ready, mem_we, done, err, core_rst_n});
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bus got addr=%h data=%h expected 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready got %b expected 0", rx_ready);
        end
    endtask

    task automatic test_back_to_back();
        wr_addr.delete();
        wr_data.delete();
        do_start();
        vectors++;
        if (rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hdr_ready got %b expected 1", rx_ready);
        end
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h0050_0093, 1'b0);
        send_word(32'h00A0_0113, 1'b0);
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h00A0_0113 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_last_write got we=%b addr=%h data=%h done=%b expected 1/4/00a00113/0",
                     mem_we, mem_addr, mem_wdata, done);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done got done=%b crst=%b we=%b expected 1/1/0", done, core_rst_n, mem_we);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0050_0093 ||
            wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00A0_0113) begin
            miscompares++;
            $display("FAIL b2b_writes got n=%0d expected 2 writes 0:00500093 4:00a00113", wr_addr.size());
        end
    endtask

    task automatic test_gaps();
        wr_addr.delete();
        wr_data.delete();
        do_start();
        vectors++;
        if (done !== 1'b0 || core_rst_n !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_from_done got done=%b crst=%b rdy=%b expected 0/0/1",
                     done, core_rst_n, rx_ready);
        end
        send_word(32'h0000_0002, 1'b1);
        do_start();
        send_word(32'h0050_0093, 1'b1);
        send_word(32'h00A0_0113, 1'b1);
        wait_done();
        vectors++;
        if (done !== 1'b1 || core_rst_n !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_done got done=%b crst=%b expected 1/1", done, core_rst_n);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0050_0093 ||
            wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00A0_0113) begin
            miscompares++;
            $display("FAIL gaps_writes got n=%0d expected 2 writes 0:00500093 4:00a00113", wr_addr.size());
        end
    endtask

    task automatic test_zero_header();
        wr_addr.delete();
        wr_data.delete();
        do_start();
        send_word(32'h0000_0000, 1'b0);
        vectors++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_hdr_done got done=%b crst=%b rdy=%b expected 1/1/0",
                     done, core_rst_n, rx_ready);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 0) begin
            miscompares++;
            $display("FAIL zero_hdr_writes got %0d expected 0", wr_addr.size());
        end
    endtask

    task automatic test_err();
        wr_addr.delete();
        wr_data.delete();
        do_start();
        send_word(32'h0000_0400, 1'b0);
        vectors++;
        if (err !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hdr_at_depth got err=%b rdy=%b expected 0/1", err, rx_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_start();
        send_word(32'h0000_0401, 1'b0);
        vectors++;
        if (err !== 1'b1 || core_rst_n !== 1'b0 || done !== 1'b0 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hdr_over_depth got err=%b crst=%b done=%b rdy=%b expected 1/0/0/0",
                     err, core_rst_n, done, rx_ready);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_hold got writes=%0d err=%b expected 0/1", wr_addr.size(), err);
        end
        do_start();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got %b expected 0", err);
        end
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL err_recover got done=%b writes=%0d expected 1 and one write 0:deadbeef",
                     done, wr_addr.size());
        end
    endtask

    task automatic test_rst_mid_load();
        wr_addr.delete();
        wr_data.delete();
        do_start();
        send_word(32'h0000_0003, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h77, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (rx_ready !== 1'b0 || core_rst_n !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got rdy=%b crst=%b done=%b we=%b expected 0/0/0/0",
                     rx_ready, core_rst_n, done, mem_we);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h1122_3344) begin
            miscompares++;
            $display("FAIL rst_mid_writes got n=%0d expected 1 write 0:11223344", wr_addr.size());
        end
        wr_addr.delete();
        wr_data.delete();
        do_start();
        send_word(32'h0000_0003, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_word(32'h5566_7788, 1'b0);
        send_word(32'h99AA_BBCC, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || core_rst_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_done got done=%b crst=%b expected 1/1", done, core_rst_n);
        end
        vectors++;
        if (wr_addr.size() != 3 || wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h4 || wr_addr[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL reload_addrs got n=%0d expected addrs 0,4,8", wr_addr.size());
        end
        vectors++;
        if (imem[0] !== 32'h1122_3344 || imem[1] !== 32'h5566_7788 || imem[2] !== 32'h99AA_BBCC) begin
            miscompares++;
            $display("FAIL reload_data got %h %h %h expected 11223344 55667788 99aabbcc",
                     imem[0], imem[1], imem[2]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 16; i++) imem[i] = 32'h0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_header();
        test_err();
        test_rst_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
